bus_lane_packer: RTL and testbench



---
 rtl/bus_lane_packer.sv | 71 +++++++
 tb/tb_bus_lane_packer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bus_lane_packer.sv
// Gathers LANE_W-bit lanes (lane 0 = LSB) into an LANES-wide word, with early termination via in_last.
// The output word is visible the edge after its completing lane; stalls hold the word and deassert in_ready.
`timescale 1ns/1ps
module bus_lane_packer #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANE_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [LANE_W*LANES-1:0] out_data,
  output logic [LANES-1:0]        out_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W:0]          lanes_held
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IDX_W-1:0]        idx;
  logic [LANE_W*LANES-1:0] asm_word;
  logic [LANE_W*LANES-1:0] merged;
  logic [LANES-1:0]        keep_mask;
  logic                    accept;
  logic                    complete;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign complete   = accept && ((idx == LAST_IDX) || in_last);
  assign lanes_held = {1'b0, idx};

  // Completed word is the assembly register with the arriving lane dropped into slot idx.
  always_comb begin
    merged = asm_word;
    merged[idx*LANE_W +: LANE_W] = in_data;
    keep_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      keep_mask[k] = (k <= int'(idx));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      asm_word  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else if (complete) begin
      // Also covers a same-cycle handoff: the new word replaces the old with no bubble.
      out_data  <= merged;
      out_keep  <= keep_mask;
      out_valid <= 1'b1;
      idx       <= '0;
      asm_word  <= '0;
    end else begin
      if (accept) begin
        asm_word[idx*LANE_W +: LANE_W] <= in_data;
        idx <= idx + 1'b1;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_lane_packer.sv
// Directed bench for bus_lane_packer: 8x4 instance for the main sequence, 16x1 instance for the single-lane case.
`timescale 1ns/1ps
module tb_bus_lane_packer;

  logic        clk;
  logic        rst_n;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  lanes_held;

  logic [15:0] b_in_data;
  logic        b_in_valid;
  logic        b_in_last;
  logic        b_in_ready;
  logic [15:0] b_out_data;
  logic [0:0]  b_out_keep;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_lanes_held;

  int errors = 0;
  int checks = 0;

  bus_lane_packer #(.LANE_W(8), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
    .lanes_held(lanes_held)
  );

  bus_lane_packer #(.LANE_W(16), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .lanes_held(b_lanes_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
  endtask

  initial begin
    rst_n = 1'b1;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_keep", out_keep, 0);
    check("rst_lanes_held", lanes_held, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    #10 rst_n = 1'b1;

    // Full word 0x44332211
    lane(8'h11, 0); check("full_held1", lanes_held, 1);
    lane(8'h22, 0); check("full_held2", lanes_held, 2);
    lane(8'h33, 0); check("full_held3", lanes_held, 3);
    check("full_not_yet_valid", out_valid, 0);
    lane(8'h44, 0);
    check("full_valid", out_valid, 1);
    check("full_data", out_data, 32'h44332211);
    check("full_keep", out_keep, 4'hF);
    check("full_held0", lanes_held, 0);

    // Early termination
    lane(8'hAA, 0);
    check("early_handoff", out_valid, 0);
    check("early_held1", lanes_held, 1);
    lane(8'hBB, 1);
    check("early_valid", out_valid, 1);
    check("early_data", out_data, 32'h0000BBAA);
    check("early_keep", out_keep, 4'h3);
    check("early_held0", lanes_held, 0);
    lane(8'hCC, 0);
    check("next_lane0_held", lanes_held, 1);
    lane(8'hDD, 1);
    check("next_lane0_data", out_data, 32'h0000DDCC);

    // Backpressure
    lane(8'h11, 0); lane(8'h22, 0); lane(8'h33, 0); lane(8'h44, 0);
    check("bp_word_valid", out_valid, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 32'h44332211);
      check("bp_hold_keep", out_keep, 4'hF);
      check("bp_hold_held", lanes_held, 0);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    check("bp_handoff", out_valid, 0);
    check("bp_resume_held", lanes_held, 1);
    lane(8'h66, 1);
    check("bp_resume_data", out_data, 32'h00006655);
    check("bp_resume_keep", out_keep, 4'h3);

    // Continuous in_last: one word per cycle, no bubble
    for (int i = 1; i <= 8; i++) begin
      lane(8'(i), 1);
      check("cont_valid", out_valid, 1);
      check("cont_data", out_data, 64'(i));
      check("cont_keep", out_keep, 4'h1);
    end

    // Asynchronous reset mid-word
    lane(8'h55, 0);
    lane(8'h66, 0);
    check("arst_pre_held", lanes_held, 2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_keep", out_keep, 0);
    check("arst_held", lanes_held, 0);
    #1 rst_n = 1'b1;
    lane(8'h77, 0); lane(8'h88, 0); lane(8'h99, 0); lane(8'hAA, 0);
    check("arst_word_valid", out_valid, 1);
    check("arst_word_data", out_data, 32'hAA998877);
    check("arst_word_keep", out_keep, 4'hF);
    in_valid = 1'b0;

    // Single-lane configuration
    b_in_valid = 1'b1; b_in_data = 16'h1234; b_in_last = 1'b0;
    step();
    check("one_valid_a", b_out_valid, 1);
    check("one_data_a", b_out_data, 16'h1234);
    check("one_keep_a", b_out_keep, 1);
    b_in_data = 16'hBEEF;
    step();
    check("one_valid_b", b_out_valid, 1);
    check("one_data_b", b_out_data, 16'hBEEF);
    check("one_keep_b", b_out_keep, 1);
    check("one_held", b_lanes_held, 0);
    b_in_valid = 1'b0;
    step();
    check("one_drain", b_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
